// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 raster scan generator.
// Issues fetch coordinates to the graphics pipeline, realigns the timing
// flags with the returned colour, and registers everything at the pins.
module vga_scan #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   LATENCY  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_r,
  input  logic [3:0]  i_g,
  input  logic [3:0]  i_b,
  output logic [10:0] o_x_read,
  output logic [10:0] o_y_read,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame_done
);

  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        de0, hs0, vs0;
  logic        de_l, hs_l, vs_l;
  logic [11:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        frame_done_q, frame_done_d;

  // Next raster position: column wraps every line, line wraps every frame.
  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + 11'd1;
      end
    end
  end

  // Raster position counters; they double as the fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign o_x_read = hcnt_q;
  assign o_y_read = vcnt_q;

  // Timing flags for the position currently being fetched (true = active).
  always_comb begin
    de0 = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    hs0 = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
    vs0 = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
  end

  // Delay the flags by the graphics latency so they meet their own colour.
  if (LATENCY == 0) begin : g_no_align
    assign de_l = de0;
    assign hs_l = hs0;
    assign vs_l = vs0;
  end else begin : g_align
    logic [LATENCY-1:0] de_pipe_q, de_pipe_d;
    logic [LATENCY-1:0] hs_pipe_q, hs_pipe_d;
    logic [LATENCY-1:0] vs_pipe_q, vs_pipe_d;

    // Shift the newest flags in at stage 0, oldest stage feeds the pins.
    always_comb begin
      de_pipe_d    = de_pipe_q;
      hs_pipe_d    = hs_pipe_q;
      vs_pipe_d    = vs_pipe_q;
      de_pipe_d[0] = de0;
      hs_pipe_d[0] = hs0;
      vs_pipe_d[0] = vs0;
      for (int i = 1; i < LATENCY; i++) begin
        de_pipe_d[i] = de_pipe_q[i-1];
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
      end
    end

    // Alignment stages clear to inactive so nothing stale reaches the pins.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        de_pipe_q <= '0;
        hs_pipe_q <= '0;
        vs_pipe_q <= '0;
      end else begin
        de_pipe_q <= de_pipe_d;
        hs_pipe_q <= hs_pipe_d;
        vs_pipe_q <= vs_pipe_d;
      end
    end

    assign de_l = de_pipe_q[LATENCY-1];
    assign hs_l = hs_pipe_q[LATENCY-1];
    assign vs_l = vs_pipe_q[LATENCY-1];
  end

  // Pin values: blank colour outside the visible area, apply sync polarity.
  always_comb begin
    rgb_d        = de_l ? {i_r, i_g, i_b} : 12'h000;
    de_d         = de_l;
    hs_d         = hs_l ? HS_POL : ~HS_POL;
    vs_d         = vs_l ? VS_POL : ~VS_POL;
    frame_done_d = (hcnt_q == 11'd0) && (vcnt_q == V_VIS);
  end

  // Output register so every pin changes on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q        <= 12'h000;
      de_q         <= 1'b0;
      hs_q         <= ~HS_POL;
      vs_q         <= ~VS_POL;
      frame_done_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign {o_r, o_g, o_b} = rgb_q;
  assign o_de            = de_q;
  assign o_hs            = hs_q;
  assign o_vs            = vs_q;
  assign o_frame_done    = frame_done_q;

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: drives four scan generators (full 640x480 geometry plus three
// shrunken rasters with latencies 0, 5 and 2) from a behavioural graphics
// model and compares every pin against raster arithmetic each cycle.
module tb_vga_scan;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    int lat;
    bit hpol, vpol;
  } geom_t;

  typedef struct {
    int n;
    int x;
    int y;
    bit de;
    bit hs;
  } vec_t;

  localparam int NI = 4;
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ir[NI], ig[NI], ib[NI];
  logic [3:0]  orr[NI], og[NI], ob[NI];
  logic [10:0] xr[NI], yr[NI];
  logic        hs[NI], vs[NI], de[NI], fd[NI];

  logic [11:0] fc[NI];
  logic [11:0] dl[NI][8];
  logic [11:0] ring[NI][16];
  geom_t       g[NI];
  vec_t        tbl[NV];
  int          n;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  // Graphics model outputs: fetch colour delayed by each instance's latency.
  assign {ir[0], ig[0], ib[0]} = dl[0][1];
  assign {ir[1], ig[1], ib[1]} = fc[1];
  assign {ir[2], ig[2], ib[2]} = dl[2][4];
  assign {ir[3], ig[3], ib[3]} = dl[3][1];

  vga_scan u_def (
    .clk(clk), .rst(rst), .i_r(ir[0]), .i_g(ig[0]), .i_b(ib[0]),
    .o_x_read(xr[0]), .o_y_read(yr[0]), .o_r(orr[0]), .o_g(og[0]), .o_b(ob[0]),
    .o_hs(hs[0]), .o_vs(vs[0]), .o_de(de[0]), .o_frame_done(fd[0]));

  vga_scan #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
             .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
             .LATENCY(0), .HS_POL(1'b1), .VS_POL(1'b1)) u_l0 (
    .clk(clk), .rst(rst), .i_r(ir[1]), .i_g(ig[1]), .i_b(ib[1]),
    .o_x_read(xr[1]), .o_y_read(yr[1]), .o_r(orr[1]), .o_g(og[1]), .o_b(ob[1]),
    .o_hs(hs[1]), .o_vs(vs[1]), .o_de(de[1]), .o_frame_done(fd[1]));

  vga_scan #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
             .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
             .LATENCY(5), .HS_POL(1'b0), .VS_POL(1'b0)) u_l5 (
    .clk(clk), .rst(rst), .i_r(ir[2]), .i_g(ig[2]), .i_b(ib[2]),
    .o_x_read(xr[2]), .o_y_read(yr[2]), .o_r(orr[2]), .o_g(og[2]), .o_b(ob[2]),
    .o_hs(hs[2]), .o_vs(vs[2]), .o_de(de[2]), .o_frame_done(fd[2]));

  vga_scan #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
             .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
             .LATENCY(2), .HS_POL(1'b0), .VS_POL(1'b0)) u_l2 (
    .clk(clk), .rst(rst), .i_r(ir[3]), .i_g(ig[3]), .i_b(ib[3]),
    .o_x_read(xr[3]), .o_y_read(yr[3]), .o_r(orr[3]), .o_g(og[3]), .o_b(ob[3]),
    .o_hs(hs[3]), .o_vs(vs[3]), .o_de(de[3]), .o_frame_done(fd[3]));

  // Expected pins after n clock edges since reset release, from raster rules.
  function automatic void model(input int i, input int nn,
                                output logic [10:0] ex, output logic [10:0] ey,
                                output logic [11:0] ergb, output logic ede,
                                output logic ehs, output logic evs, output logic efd);
    int ht, vt, k, xk, yk;
    ht   = g[i].ha + g[i].hfp + g[i].hsw + g[i].hbp;
    vt   = g[i].va + g[i].vfp + g[i].vsw + g[i].vbp;
    ex   = 11'(nn % ht);
    ey   = 11'((nn / ht) % vt);
    k    = nn - 1 - g[i].lat;
    ede  = 1'b0;
    ergb = 12'h000;
    ehs  = ~g[i].hpol;
    evs  = ~g[i].vpol;
    if (k >= 0) begin
      xk  = k % ht;
      yk  = (k / ht) % vt;
      ede = (xk < g[i].ha) && (yk < g[i].va);
      if (xk >= g[i].ha + g[i].hfp && xk < g[i].ha + g[i].hfp + g[i].hsw) ehs = g[i].hpol;
      if (yk >= g[i].va + g[i].vfp && yk < g[i].va + g[i].vfp + g[i].vsw) evs = g[i].vpol;
      if (ede) ergb = ring[i][k % 16];
    end
    efd = (nn >= 1) && (((nn - 1) % (ht * vt)) == g[i].va * ht);
  endfunction

  task automatic cmp(input string tag, input int i, input string nm,
                     input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s inst%0d %s n=%0d got %h want %h", tag, i, nm, n, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Graphics returns {x[3:0], y[3:0], random} for the coordinate just issued
  // (or white), and the model records what that fetch at raster index n holds.
  task automatic applyStimulus(input bit white);
    int ht, vt, xm, ym;
    logic [3:0] rnd;
    for (int i = 0; i < NI; i++) begin
      ht  = g[i].ha + g[i].hfp + g[i].hsw + g[i].hbp;
      vt  = g[i].va + g[i].vfp + g[i].vsw + g[i].vbp;
      xm  = n % ht;
      ym  = (n / ht) % vt;
      rnd = 4'($urandom_range(0, 15));
      ring[i][n % 16] = white ? 12'hFFF : {4'(xm), 4'(ym), rnd};
      fc[i]           = white ? 12'hFFF : {xr[i][3:0], yr[i][3:0], rnd};
    end
  endtask

  task automatic shiftPipes();
    for (int i = 0; i < NI; i++) begin
      for (int j = 7; j > 0; j--) dl[i][j] = dl[i][j-1];
      dl[i][0] = fc[i];
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [10:0] ex, ey;
    logic [11:0] ergb;
    logic ede, ehs, evs, efd;
    for (int i = 0; i < NI; i++) begin
      model(i, n, ex, ey, ergb, ede, ehs, evs, efd);
      cmp(tag, i, "x_read", 12'(xr[i]), 12'(ex));
      cmp(tag, i, "y_read", 12'(yr[i]), 12'(ey));
      cmp(tag, i, "rgb", {orr[i], og[i], ob[i]}, ergb);
      cmp(tag, i, "de", 12'(de[i]), 12'(ede));
      cmp(tag, i, "hs", 12'(hs[i]), 12'(ehs));
      cmp(tag, i, "vs", 12'(vs[i]), 12'(evs));
      cmp(tag, i, "frame_done", 12'(fd[i]), 12'(efd));
    end
  endtask

  // One clock: advance the raster index, check pins, then issue next fetch.
  task automatic runCycle(input string tag, input bit white, input bit vectors);
    @(posedge clk);
    #1;
    n++;
    shiftPipes();
    checkOutput(tag);
    if (vectors) begin
      for (int v = 0; v < NV; v++) begin
        if (tbl[v].n == n) begin
          cmp("vec", 0, "x_read", 12'(xr[0]), 12'(tbl[v].x));
          cmp("vec", 0, "y_read", 12'(yr[0]), 12'(tbl[v].y));
          cmp("vec", 0, "de", 12'(de[0]), 12'(tbl[v].de));
          cmp("vec", 0, "hs", 12'(hs[0]), 12'(tbl[v].hs));
        end
      end
    end
    applyStimulus(white);
  endtask

  // Hold reset for a few edges with every pin checked against reset values.
  task automatic holdReset(input string tag);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      shiftPipes();
      applyStimulus(1'b1);
      checkOutput(tag);
    end
    applyStimulus(1'b0);
  endtask

  initial begin
    g[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
    g[1] = '{20, 3, 5, 4, 6, 2, 2, 3, 0, 1'b1, 1'b1};
    g[2] = '{20, 3, 5, 4, 6, 2, 2, 3, 5, 1'b0, 1'b0};
    g[3] = '{20, 3, 5, 4, 6, 2, 2, 3, 2, 1'b0, 1'b0};

    // Hand-derived landmarks of the full-size raster (LATENCY 2, active-low sync).
    tbl[0]  = '{1,   1,   0, 1'b0, 1'b1};
    tbl[1]  = '{2,   2,   0, 1'b0, 1'b1};
    tbl[2]  = '{3,   3,   0, 1'b1, 1'b1};
    tbl[3]  = '{642, 642, 0, 1'b1, 1'b1};
    tbl[4]  = '{643, 643, 0, 1'b0, 1'b1};
    tbl[5]  = '{658, 658, 0, 1'b0, 1'b1};
    tbl[6]  = '{659, 659, 0, 1'b0, 1'b0};
    tbl[7]  = '{754, 754, 0, 1'b0, 1'b0};
    tbl[8]  = '{755, 755, 0, 1'b0, 1'b1};
    tbl[9]  = '{800, 0,   1, 1'b0, 1'b1};
    tbl[10] = '{803, 3,   1, 1'b1, 1'b1};

    for (int i = 0; i < NI; i++) begin
      fc[i] = 12'hFFF;
      for (int j = 0; j < 8; j++) dl[i][j] = 12'hFFF;
      for (int j = 0; j < 16; j++) ring[i][j] = 12'h000;
    end

    rst = 1'b1;
    n   = 0;
    #1;
    checkOutput("reset_async");
    holdReset("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 1000; c++) runCycle("pixel", 1'b0, 1'b1);
    for (int c = 0; c < 900; c++) runCycle("white", 1'b1, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    n = 0;
    checkOutput("midframe_reset");
    applyStimulus(1'b1);
    holdReset("midframe_hold");
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 2000; c++) runCycle("resume", ($urandom_range(0, 7) == 0), 1'b0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
# vga_scan

VGA 640x480@60 scan generator driving the graphics pixel pipeline and the monitor pins. It produces the read coordinates (`o_x_read`, `o_y_read`) that the graphics block turns into RGB, and accepts that RGB back a fixed number of cycles later. It then emits pixel-aligned sync, data-enable and colour to the connector. It also gives the game state machine a once-per-frame update strobe.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `LATENCY`, 2: clk cycles from `o_x_read`/`o_y_read` to the matching `i_r`/`i_g`/`i_b`; legal range 0..7.
- `HS_POL`, 0: active level of `o_hs`.
- `VS_POL`, 0: active level of `o_vs`.
- `clk` in 1: pixel clock (25.175 MHz nominal). One clock only.
- `rst` in 1: reset, asynchronous and active-high.
- `i_r`, `i_g`, `i_b` in 4 each: pixel colour returned by graphics for the coordinates issued `LATENCY` cycles earlier.
- `o_x_read` out 11: fetch column, 0..H_TOTAL-1.
- `o_y_read` out 11: fetch line, 0..V_TOTAL-1.
- `o_r`, `o_g`, `o_b` out 4 each: colour to the DAC.
- `o_hs` out 1: horizontal sync to the connector.
- `o_vs` out 1: vertical sync to the connector.
- `o_de` out 1: display enable, aligned with `o_r`/`o_g`/`o_b`.
- `o_frame_done` out 1: one-cycle strobe at the start of vertical blanking.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525. Both counters are 11 bit unsigned.
- Fetch counters `hcnt`/`vcnt`:
  - `hcnt` increments every clk.
  - At H_TOTAL-1, `hcnt` wraps to 0 and `vcnt` increments.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0.
  - `o_x_read = hcnt` and `o_y_read = vcnt` combinationally, including during blanking. Graphics output outside the active area is discarded.
- Stage-0 timing flags, decoded from the counters:
  - `de0 = hcnt<H_ACTIVE && vcnt<V_ACTIVE`.
  - `hs0` active for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - `vs0` active for `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491], over whole lines.
- Alignment: `de0`/`hs0`/`vs0` pass through a `LATENCY`-deep shift register, giving `deL`/`hsL`/`vsL`. With `LATENCY=0` the shift register is a wire.
- Output register, updated every clk:
  - `{o_r,o_g,o_b} <= deL ? {i_r,i_g,i_b} : 12'h000`.
  - `o_de <= deL`.
  - `o_hs <= hsL ? HS_POL : ~HS_POL`.
  - `o_vs <= vsL ? VS_POL : ~VS_POL`.
- `o_frame_done` is registered. It is high for exactly one cycle, the cycle after the fetch counters equal (0, V_ACTIVE) = (0, 480). Graphics does not fetch visible pixels again until line 0.

## Timing
- Reset (async assert; the first increment happens on the first clk edge after deassert):
  - `hcnt = vcnt = 0`, so `o_x_read = o_y_read = 0`.
  - All shift-register stages hold the inactive state.
  - `o_r = o_g = o_b = 0`, `o_de = 0`, `o_hs = ~HS_POL`, `o_vs = ~VS_POL`, `o_frame_done = 0`.
- Pin latency: pins at cycle t reflect fetch coordinates from cycle t-(LATENCY+1). The first pixel (0,0) after reset appears on the pins LATENCY+1 cycles after the first clk with the counters at (0,0).
- Sync latency: the sync pulses carry the same LATENCY+1 delay as colour. hs/vs-to-pixel relationships therefore match the VESA 640x480 timing exactly at the pins.
- Line period is 800 clk. Frame period is 420000 clk. The hsync pulse is 96 clk and the vsync pulse is 1600 clk.
- Reset mid-frame: all outputs return to their reset values asynchronously. Scanning restarts at (0,0) and no partial pipeline contents leak out. `o_frame_done` does not pulse until the next time the counters reach (0, 480).
- Input contract: `i_r`/`i_g`/`i_b` are sampled every clk without a handshake. Graphics must have a constant latency equal to `LATENCY`.

## Test plan
- Reset values: hold `rst` high with `i_rgb = 12'hFFF` and check every output equals its reset value. Release `rst`: `o_x_read` runs 0,1,2,… and `o_de` first rises on cycle 3 (`LATENCY=2`).
- Line and frame geometry: over 2 frames check:
  - `o_de` is high 640 of every 800 cycles, on lines 0..479 only.
  - `o_hs` is low for 96 cycles, with its falling edge 16 cycles after `o_de` falls.
  - `o_vs` is low for 1600 cycles, starting 10 lines after the last active line.
  - The frame period is 420000 cycles.
- Pixel alignment: a bench model with a 2-cycle pipeline returns `{x[3:0], y[3:0], 4'h5}` for each fetched (x,y). While `o_de=1`, every pin colour must decode to the pixel's own coordinates. The first pixel is (0,0) and the last is (639,479).
- Blanking forces black: drive `i_rgb = 12'hFFF` constantly. Pins show `12'hFFF` when `o_de=1` and `12'h000` whenever `o_de=0`, including during the porches and sync.
- Frame strobe: `o_frame_done` pulses exactly once per 420000 cycles, one cycle after `o_x_read=0` and `o_y_read=480`, and is never high for 2 consecutive cycles.
- Mid-frame reset and parameter variant:
  - Assert `rst` at (x=300, y=200): outputs go to reset values immediately, then after release the scan resumes at (0,0) with correct alignment.
  - Repeat the alignment test with `LATENCY=0` and `LATENCY=5`.
